// File: rtl/pl_reg_mw_mt.sv
// MEM->WB pipeline register for the barrel RV32 core: DEPTH stages with per-thread
// flush, writeback result select and per-thread retired-instruction counters.
module pl_reg_mw_mt #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_THREADS   = 8,
  parameter int DEPTH         = 1,
  parameter int CNT_WIDTH     = 32,
  localparam int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     stall,
  input  logic [NUM_THREADS-1:0]   flush_mask,
  input  logic                     valid_m,
  input  logic                     reg_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [DATA_WIDTH-1:0]    alu_result_m,
  input  logic [DATA_WIDTH-1:0]    read_data_m,
  input  logic [4:0]               rd_m,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  input  logic [BITS_THREADS-1:0]  tid_m,
  input  logic [BITS_THREADS-1:0]  cnt_tid,
  output logic                     valid_w,
  output logic                     reg_write_w,
  output logic [4:0]               rd_w,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic [BITS_THREADS-1:0]  tid_w,
  output logic [CNT_WIDTH-1:0]     instret
);

  logic                     vld_p   [DEPTH];
  logic                     wr_p    [DEPTH];
  logic [1:0]               src_p   [DEPTH];
  logic [DATA_WIDTH-1:0]    alu_p   [DEPTH];
  logic [DATA_WIDTH-1:0]    mem_p   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_p    [DEPTH];
  logic [4:0]               rd_p    [DEPTH];
  logic [BITS_THREADS-1:0]  tid_p   [DEPTH];

  logic                     vld_in  [DEPTH];
  logic [BITS_THREADS-1:0]  tid_in  [DEPTH];
  logic                     vld_nx  [DEPTH];
  logic [CNT_WIDTH-1:0]     cnt     [NUM_THREADS];

  // Thread ids beyond NUM_THREADS have no flush bit and are never killed.
  function automatic logic flush_hit(input logic [BITS_THREADS-1:0] tid,
                                     input logic [NUM_THREADS-1:0] mask);
    logic hit;
    hit = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++)
      if (tid == BITS_THREADS'(t)) hit = mask[t];
    return hit;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sel_result(input logic [1:0] src,
      input logic [DATA_WIDTH-1:0] alu, input logic [DATA_WIDTH-1:0] mem,
      input logic [ADDRESS_WIDTH-1:0] pc);
    case (src)
      2'b01:   return mem;
      2'b10:   return DATA_WIDTH'(pc);
      default: return alu;
    endcase
  endfunction

  // Source of each stage's next valid/tid: itself when stalled, the stage before otherwise.
  always_comb begin
    vld_in[0] = valid_m;
    tid_in[0] = tid_m;
    for (int k = 1; k < DEPTH; k++) begin
      vld_in[k] = vld_p[k-1];
      tid_in[k] = tid_p[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (stall)
        vld_nx[k] = vld_p[k] & ~flush_hit(tid_p[k], flush_mask);
      else
        vld_nx[k] = vld_in[k] & ~flush_hit(tid_in[k], flush_mask);
    end
  end

  // ---- stage 0 .. DEPTH-1 registers ----
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k] <= 1'b0;
        wr_p[k]  <= 1'b0;
        src_p[k] <= '0;
        alu_p[k] <= '0;
        mem_p[k] <= '0;
        pc_p[k]  <= '0;
        rd_p[k]  <= '0;
        tid_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) vld_p[k] <= vld_nx[k];
      if (!stall) begin
        wr_p[0]  <= reg_write_m;
        src_p[0] <= result_src_m;
        alu_p[0] <= alu_result_m;
        mem_p[0] <= read_data_m;
        pc_p[0]  <= pc_plus4_m;
        rd_p[0]  <= rd_m;
        tid_p[0] <= tid_m;
        for (int k = 1; k < DEPTH; k++) begin
          wr_p[k]  <= wr_p[k-1];
          src_p[k] <= src_p[k-1];
          alu_p[k] <= alu_p[k-1];
          mem_p[k] <= mem_p[k-1];
          pc_p[k]  <= pc_p[k-1];
          rd_p[k]  <= rd_p[k-1];
          tid_p[k] <= tid_p[k-1];
        end
      end
    end
  end

  // ---- retire counters: the output-stage instruction retires even if flushed now ----
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int t = 0; t < NUM_THREADS; t++) cnt[t] <= '0;
    end else if (!stall && vld_p[DEPTH-1]) begin
      for (int t = 0; t < NUM_THREADS; t++)
        if (tid_p[DEPTH-1] == BITS_THREADS'(t)) cnt[t] <= cnt[t] + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    instret = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      if (cnt_tid == BITS_THREADS'(t)) instret = cnt[t];
  end

  assign valid_w     = vld_p[DEPTH-1];
  assign rd_w        = rd_p[DEPTH-1];
  assign tid_w       = tid_p[DEPTH-1];
  assign reg_write_w = vld_p[DEPTH-1] & wr_p[DEPTH-1] & (rd_p[DEPTH-1] != 5'd0);
  assign result_w    = sel_result(src_p[DEPTH-1], alu_p[DEPTH-1], mem_p[DEPTH-1], pc_p[DEPTH-1]);

endmodule

// File: tb/tb_pl_reg_mw_mt.sv
// Bench for pl_reg_mw_mt: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level model of the writeback pipe.
module tb_pl_reg_mw_mt;
  localparam int AW = 32, DW = 32, NT = 6, DP = 3, CW = 4, BT = 3;

  logic          clk = 1'b0;
  logic          clr, stall, valid_m, reg_write_m;
  logic [NT-1:0] flush_mask;
  logic [1:0]    result_src_m;
  logic [DW-1:0] alu_result_m, read_data_m;
  logic [4:0]    rd_m;
  logic [AW-1:0] pc_plus4_m;
  logic [BT-1:0] tid_m, cnt_tid;
  logic          valid_w, reg_write_w;
  logic [4:0]    rd_w;
  logic [DW-1:0] result_w;
  logic [BT-1:0] tid_w;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  pl_reg_mw_mt #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_THREADS(NT),
                 .DEPTH(DP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clr(clr), .stall(stall), .flush_mask(flush_mask),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .rd_m(rd_m),
    .pc_plus4_m(pc_plus4_m), .tid_m(tid_m), .cnt_tid(cnt_tid),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .tid_w(tid_w), .instret(instret));

  typedef struct {
    logic v; logic rw; logic [1:0] src;
    logic [31:0] alu; logic [31:0] rdat; logic [31:0] pc;
    logic [4:0] rd; logic [2:0] tid;
  } ent_t;

  typedef struct {
    logic v; logic rw; logic [1:0] src;
    logic [31:0] alu; logic [31:0] rdat; logic [31:0] pc;
    logic [4:0] rd; logic [2:0] tid;
    logic e_v; logic e_rw; logic [4:0] e_rd; logic [31:0] e_res;
    logic [2:0] e_tid; logic [3:0] e_cnt;
  } vec_t;

  ent_t        pipe [DP];
  int unsigned cnt  [8];
  vec_t        tbl  [7];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic st, input logic [7:0] fm, input logic v, input logic rw,
                        input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [2:0] tid);
    stall = st; flush_mask = fm[NT-1:0]; valid_m = v; reg_write_m = rw;
    result_src_m = src; alu_result_m = alu; read_data_m = rdat; rd_m = rd;
    pc_plus4_m = pc; tid_m = tid;
  endtask

  // Transaction-level view: a list of DP in-flight instructions plus retire tallies.
  task automatic model_edge();
    ent_t nw;
    if (clr) begin
      for (int i = 0; i < DP; i++) pipe[i] = '{default: '0};
      for (int t = 0; t < 8; t++) cnt[t] = 0;
    end else begin
      if (!stall && pipe[DP-1].v && int'(pipe[DP-1].tid) < NT)
        cnt[pipe[DP-1].tid] = cnt[pipe[DP-1].tid] + 1;
      if (!stall) begin
        nw = '{valid_m, reg_write_m, result_src_m, alu_result_m, read_data_m,
               pc_plus4_m, rd_m, tid_m};
        for (int i = DP-1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = nw;
      end
      for (int i = 0; i < DP; i++)
        if (int'(pipe[i].tid) < NT && flush_mask[pipe[i].tid]) pipe[i].v = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model();
    ent_t o;
    logic [31:0] res, ic;
    o = pipe[DP-1];
    res = (o.src == 2'b01) ? o.rdat : (o.src == 2'b10) ? o.pc : o.alu;
    ic  = (int'(cnt_tid) < NT) ? (cnt[cnt_tid] % 16) : 0;
    chk("rnd_valid_w", 32'(valid_w), 32'(o.v));
    chk("rnd_reg_write_w", 32'(reg_write_w), 32'(o.v & o.rw & (o.rd != 0)));
    chk("rnd_rd_w", 32'(rd_w), 32'(o.rd));
    chk("rnd_tid_w", 32'(tid_w), 32'(o.tid));
    chk("rnd_result_w", result_w, res);
    chk("rnd_instret", 32'(instret), ic);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DP; i++) pipe[i] = '{default: '0};
    for (int t = 0; t < 8; t++) cnt[t] = 0;
    cnt_tid = 0;

    // Reset overrides stall and flush while live-looking inputs are applied.
    clr = 1'b1;
    set_in(1, 8'hFF, 1, 1, 2'b10, 32'hDEAD, 32'hBEEF, 5'd7, 32'h44, 3'd2);
    tick();
    chk("rst_valid_w", 32'(valid_w), 0);
    chk("rst_reg_write_w", 32'(reg_write_w), 0);
    chk("rst_rd_w", 32'(rd_w), 0);
    chk("rst_result_w", result_w, 0);
    chk("rst_tid_w", 32'(tid_w), 0);
    chk("rst_instret", 32'(instret), 0);
    clr = 1'b0;

    // Back-to-back alu/load/pc+4 ops on thread 1, then bubbles.
    tbl[0] = '{1,1,2'b00,32'hAAAA0001,32'hBBBB0001,32'h100,5'd1,3'd1, 0,0,5'd0,32'h0,3'd0,4'd0};
    tbl[1] = '{1,1,2'b01,32'hAAAA0002,32'hBBBB0002,32'h104,5'd2,3'd1, 0,0,5'd0,32'h0,3'd0,4'd0};
    tbl[2] = '{1,1,2'b10,32'hAAAA0003,32'hBBBB0003,32'h200,5'd0,3'd1, 1,1,5'd1,32'hAAAA0001,3'd1,4'd0};
    tbl[3] = '{0,0,2'b00,32'h0,32'h0,32'h0,5'd0,3'd0, 1,1,5'd2,32'hBBBB0002,3'd1,4'd1};
    tbl[4] = '{0,0,2'b00,32'h0,32'h0,32'h0,5'd0,3'd0, 1,0,5'd0,32'h200,3'd1,4'd2};
    tbl[5] = '{0,0,2'b00,32'h0,32'h0,32'h0,5'd0,3'd0, 0,0,5'd0,32'h0,3'd0,4'd3};
    tbl[6] = '{0,0,2'b00,32'h0,32'h0,32'h0,5'd0,3'd0, 0,0,5'd0,32'h0,3'd0,4'd3};
    cnt_tid = 3'd1;
    for (int i = 0; i < 7; i++) begin
      set_in(0, 0, tbl[i].v, tbl[i].rw, tbl[i].src, tbl[i].alu, tbl[i].rdat,
             tbl[i].rd, tbl[i].pc, tbl[i].tid);
      tick();
      chk("tbl_valid_w", 32'(valid_w), 32'(tbl[i].e_v));
      chk("tbl_reg_write_w", 32'(reg_write_w), 32'(tbl[i].e_rw));
      chk("tbl_rd_w", 32'(rd_w), 32'(tbl[i].e_rd));
      chk("tbl_result_w", result_w, tbl[i].e_res);
      chk("tbl_tid_w", 32'(tid_w), 32'(tbl[i].e_tid));
      chk("tbl_instret", 32'(instret), 32'(tbl[i].e_cnt));
    end

    // Stall two cycles with thread-4 ops in flight.
    do_reset();
    cnt_tid = 3'd4;
    set_in(0, 0, 1, 1, 0, 32'h11, 0, 5'd3, 0, 3'd4); tick();
    set_in(0, 0, 1, 1, 0, 32'h22, 0, 5'd3, 0, 3'd4); tick();
    set_in(0, 0, 1, 1, 0, 32'h33, 0, 5'd3, 0, 3'd4); tick();
    chk("stl_pre_result", result_w, 32'h11);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 1, 1, 0, 32'h99, 0, 5'd3, 0, 3'd4); tick();
      chk("stl_hold_result", result_w, 32'h11);
      chk("stl_hold_valid", 32'(valid_w), 1);
      chk("stl_hold_instret", 32'(instret), 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("stl_rel1_result", result_w, 32'h22);
    chk("stl_rel1_instret", 32'(instret), 1);
    tick();
    chk("stl_rel2_result", result_w, 32'h33);
    chk("stl_rel2_instret", 32'(instret), 2);
    tick();
    chk("stl_rel3_valid", 32'(valid_w), 0);
    chk("stl_rel3_instret", 32'(instret), 3);

    // Flush thread 2 with a thread-5 entry between killed ones.
    do_reset();
    set_in(0, 0, 1, 1, 0, 32'h21, 0, 5'd9, 0, 3'd2); tick();
    set_in(0, 0, 1, 1, 0, 32'h51, 0, 5'd9, 0, 3'd5); tick();
    set_in(0, 0, 1, 1, 0, 32'h22, 0, 5'd9, 0, 3'd2); tick();
    set_in(0, 8'h04, 1, 1, 0, 32'h23, 0, 5'd9, 0, 3'd2); tick();
    chk("fl_t5_valid", 32'(valid_w), 1);
    chk("fl_t5_tid", 32'(tid_w), 5);
    chk("fl_t5_result", result_w, 32'h51);
    cnt_tid = 3'd2;
    #0 chk("fl_t2_retired_out", 32'(instret), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_killed_valid", 32'(valid_w), 0);
      chk("fl_killed_regwr", 32'(reg_write_w), 0);
    end
    chk("fl_t2_instret", 32'(instret), 1);
    cnt_tid = 3'd5; #1;
    chk("fl_t5_instret", 32'(instret), 1);

    // Counter wrap: 17 retirements with a 4-bit counter.
    do_reset();
    cnt_tid = 3'd0;
    for (int i = 0; i < 17; i++) begin
      set_in(0, 0, 1, 1, 0, 32'(i), 0, 5'd1, 0, 3'd0); tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_instret", 32'(instret), 1);

    // Reset mid-stream while stalled and flushing.
    set_in(0, 0, 1, 1, 2'b01, 32'h5, 32'h66, 5'd4, 0, 3'd3); tick(); tick(); tick(); tick();
    clr = 1'b1;
    set_in(1, 8'h3F, 1, 1, 2'b01, 32'h5, 32'h66, 5'd4, 0, 3'd3); tick();
    clr = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_valid_w", 32'(valid_w), 0);
    chk("clr_reg_write_w", 32'(reg_write_w), 0);
    chk("clr_rd_w", 32'(rd_w), 0);
    chk("clr_result_w", result_w, 0);
    chk("clr_tid_w", 32'(tid_w), 0);
    for (int t = 0; t < 8; t++) begin
      cnt_tid = 3'(t); #1;
      chk("clr_instret", 32'(instret), 0);
    end

    // Randomized run against the model, including out-of-range thread ids.
    for (int n = 0; n < 500; n++) begin
      clr = ($urandom_range(0, 79) == 0);
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0,
             ($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), $urandom, $urandom,
             5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, 3'($urandom));
      cnt_tid = 3'($urandom);
      tick();
      cmp_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
